// File: rtl/game_turn_controller.sv
// Turn controller for a 4x4 drop-token game: accepts a column from the
// current player, drops the token into the lowest free row, waits for the
// external winner detector to settle, then either hands the turn over or
// ends the game.
module game_turn_controller #(
  parameter int CHECK_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [1:0]  move_col,
  input  logic [1:0]  win_status,
  output logic        move_ready,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        current_player,
  output logic        move_reject,
  output logic [4:0]  move_count,
  output logic        game_over,
  output logic [1:0]  result
);

  // Counter wide enough to hold CHECK_WAIT; a load of 0 or 1 samples on the
  // first CHECK cycle.
  localparam int CNT_W = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CHECK_WAIT);
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
  localparam logic [4:0]       MOVES_MAX = 5'd16;

  typedef enum logic [1:0] {
    WAIT_MOVE = 2'd0,
    DROP      = 2'd1,
    CHECK     = 2'd2,
    OVER      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      board_q, board_d;
  logic [15:0]      owner_q, owner_d;
  logic             player_q, player_d;
  logic [4:0]       count_q, count_d;
  logic [1:0]       result_q, result_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Occupancy of the captured column, bit r = row r.
  logic [3:0] col_cells;
  logic       col_has_free;
  logic [1:0] free_row;
  logic [3:0] cell_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_view
      localparam logic [1:0] ROW = gi;
      assign col_cells[gi] = board_q[{ROW, col_q}];
    end
  endgenerate

  // Lowest empty row of the captured column; scanning downward leaves the
  // lowest one as the final assignment.
  always_comb begin
    col_has_free = 1'b0;
    free_row     = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!col_cells[r]) begin
        col_has_free = 1'b1;
        free_row     = 2'(r);
      end
    end
  end

  assign cell_idx = {free_row, col_q};

  // Next-state logic; new_game overrides whatever the FSM would do.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    owner_d     = owner_q;
    player_d    = player_q;
    count_d     = count_q;
    result_d    = result_q;
    col_d       = col_q;
    wait_d      = wait_q;
    move_reject = 1'b0;

    case (state_q)
      WAIT_MOVE: begin
        if (move_valid) begin
          col_d   = move_col;
          state_d = DROP;
        end
      end
      DROP: begin
        if (col_has_free) begin
          board_d[cell_idx] = 1'b1;
          owner_d[cell_idx] = player_q;
          if (count_q < MOVES_MAX) begin
            count_d = count_q + 5'd1;
          end
          wait_d  = WAIT_LOAD;
          state_d = CHECK;
        end else begin
          move_reject = 1'b1;
          state_d     = WAIT_MOVE;
        end
      end
      CHECK: begin
        if (wait_q > WAIT_ONE) begin
          wait_d = wait_q - WAIT_ONE;
        end else begin
          wait_d = '0;
          if (win_status != 2'b00) begin
            result_d = win_status;
            state_d  = OVER;
          end else if (count_q == MOVES_MAX) begin
            // Board full with no winner reported: declare a tie ourselves.
            result_d = 2'b11;
            state_d  = OVER;
          end else begin
            player_d = ~player_q;
            state_d  = WAIT_MOVE;
          end
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = WAIT_MOVE;
      end
    endcase

    if (new_game) begin
      state_d     = WAIT_MOVE;
      board_d     = '0;
      owner_d     = '0;
      player_d    = 1'b0;
      count_d     = '0;
      result_d    = 2'b00;
      col_d       = 2'd0;
      wait_d      = '0;
      move_reject = 1'b0;
    end
  end

  // State registers; reset abandons any move in flight with no board write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_MOVE;
      board_q  <= '0;
      owner_q  <= '0;
      player_q <= 1'b0;
      count_q  <= '0;
      result_q <= 2'b00;
      col_q    <= 2'd0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      owner_q  <= owner_d;
      player_q <= player_d;
      count_q  <= count_d;
      result_q <= result_d;
      col_q    <= col_d;
      wait_q   <= wait_d;
    end
  end

  assign move_ready     = (state_q == WAIT_MOVE);
  assign game_over      = (state_q == OVER);
  assign game_board     = board_q;
  assign player_cells   = owner_q;
  assign current_player = player_q;
  assign move_count     = count_q;
  assign result         = result_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller: directed scenarios plus random games,
// checked against a row/column board model that also plays the role of the
// external winner detector.
module tb_game_turn_controller;

  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        move_valid;
  logic [1:0]  move_col;
  logic [1:0]  win_status;
  logic        move_ready;
  logic [15:0] game_board;
  logic [15:0] player_cells;
  logic        current_player;
  logic        move_reject;
  logic [4:0]  move_count;
  logic        game_over;
  logic [1:0]  result;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: board as [row][col], row 0 at the bottom.
  bit       m_occ [4][4];
  bit       m_own [4][4];
  int       m_height [4];
  bit       m_turn;
  int       m_count;
  bit       m_over;
  logic [1:0] m_result;
  bit       det_en;

  game_turn_controller #(.CHECK_WAIT(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .new_game       (new_game),
    .move_valid     (move_valid),
    .move_col       (move_col),
    .win_status     (win_status),
    .move_ready     (move_ready),
    .game_board     (game_board),
    .player_cells   (player_cells),
    .current_player (current_player),
    .move_reject    (move_reject),
    .move_count     (move_count),
    .game_over      (game_over),
    .result         (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m_occ[r][c] = 1'b0;
        m_own[r][c] = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) m_height[c] = 0;
    m_turn = 1'b0;
    m_count = 0;
    m_over = 1'b0;
    m_result = 2'b00;
    win_status = 2'b00;
  endtask

  // Four-in-a-line detector over rows, columns and both diagonals.
  function automatic logic [1:0] detect();
    for (int k = 0; k < 10; k++) begin
      int p1 = 0;
      int p2 = 0;
      for (int i = 0; i < 4; i++) begin
        int r;
        int c;
        if (k < 4) begin r = k; c = i; end
        else if (k < 8) begin r = i; c = k - 4; end
        else if (k == 8) begin r = i; c = i; end
        else begin r = i; c = 3 - i; end
        if (m_occ[r][c]) begin
          if (m_own[r][c]) p2++;
          else p1++;
        end
      end
      if (p1 == 4) return 2'b01;
      if (p2 == 4) return 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic [15:0] exp_board();
    logic [15:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_occ[r][c]) v[4*r + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] exp_owner();
    logic [15:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_occ[r][c] && m_own[r][c]) v[4*r + c] = 1'b1;
    return v;
  endfunction

  // Place a token in the model and resolve the turn; returns detector view.
  task automatic model_apply(input int col, output logic [1:0] w);
    int r;
    r = m_height[col];
    m_occ[r][col] = 1'b1;
    m_own[r][col] = m_turn;
    m_height[col]++;
    m_count++;
    w = det_en ? detect() : 2'b00;
    if (w != 2'b00) begin
      m_over = 1'b1;
      m_result = w;
    end else if (m_count == 16) begin
      m_over = 1'b1;
      m_result = 2'b11;
    end else begin
      m_turn = ~m_turn;
    end
  endtask

  task automatic compare_all();
    check_eq("board", game_board, exp_board());
    check_eq("owner", player_cells & game_board, exp_owner());
    check_eq("player", current_player, m_turn);
    check_eq("count", move_count, m_count);
    check_eq("over", game_over, m_over);
    check_eq("result", result, m_result);
    check_eq("ready", move_ready, !m_over);
  endtask

  // One move from a WAIT_MOVE negedge back to the next WAIT_MOVE/OVER negedge.
  task automatic do_move(input int col, input bit hold);
    bit full;
    int cyc;
    logic [1:0] w;
    check_eq("ready_pre", move_ready, 1);
    full = (m_height[col] == 4);
    move_valid = 1'b1;
    move_col = 2'(col);
    if (!full) begin
      model_apply(col, w);
      win_status = w;
    end
    @(negedge clk);
    if (!hold || full) move_valid = 1'b0;
    check_eq("reject", move_reject, full);
    check_eq("ready_drop", move_ready, 0);
    if (full) begin
      @(negedge clk);
      check_eq("reject_len", move_reject, 0);
    end else begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(move_ready || game_over) && cyc < 20);
      move_valid = 1'b0;
      check_eq("spacing", cyc, CW + 1);
    end
    $display("move col=%0d full=%0d count=%0d board=%h over=%0d result=%0d",
             col, full, move_count, game_board, game_over, result);
    compare_all();
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    $display("new_game board=%h count=%0d", game_board, move_count);
    compare_all();
  endtask

  // In OVER the controller must not take any request.
  task automatic poke_over();
    for (int i = 0; i < 3; i++) begin
      move_valid = 1'b1;
      move_col = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    move_valid = 1'b0;
    $display("poke_over board=%h over=%0d", game_board, game_over);
    compare_all();
  endtask

  initial begin
    reset = 1'b1;
    new_game = 1'b0;
    move_valid = 1'b0;
    move_col = 2'd0;
    win_status = 2'b00;
    det_en = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_reject", move_reject, 0);
    $display("reset board=%h ready=%0d", game_board, move_ready);
    compare_all();

    // Vertical win for P1 in column 0.
    for (int i = 0; i < 7; i++) do_move(i % 2, 1'b0);
    check_eq("vwin_over", game_over, 1);
    check_eq("vwin_result", result, 2'b01);
    check_eq("vwin_count", move_count, 7);
    poke_over();

    // Fill column 2, then request it once more.
    pulse_new_game();
    for (int i = 0; i < 5; i++) do_move(2, 1'b0);
    check_eq("colfull_count", move_count, 4);

    // Full board with a silent detector forces the tie result.
    pulse_new_game();
    det_en = 1'b0;
    for (int i = 0; i < 16; i++) do_move(i % 4, 1'b0);
    check_eq("tie_board", game_board, 16'hFFFF);
    check_eq("tie_result", result, 2'b11);
    poke_over();
    det_en = 1'b1;

    // move_valid held through DROP and CHECK takes exactly one move.
    pulse_new_game();
    do_move(1, 1'b1);
    do_move(3, 1'b1);
    check_eq("hold_count", move_count, 2);

    // new_game during CHECK after five moves.
    pulse_new_game();
    for (int i = 0; i < 5; i++) do_move(i % 4, 1'b0);
    move_valid = 1'b1;
    move_col = 2'd3;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    pulse_new_game();
    do_move(2, 1'b0);
    check_eq("ng_row0", game_board, 16'h0004);
    check_eq("ng_p1", player_cells[2], 0);

    // Reset during DROP after five moves.
    pulse_new_game();
    for (int i = 0; i < 5; i++) do_move(3 - (i % 4), 1'b0);
    move_valid = 1'b1;
    move_col = 2'd1;
    @(negedge clk);
    move_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("reset_in_drop board=%h count=%0d", game_board, move_count);
    compare_all();
    check_eq("rst_reject2", move_reject, 0);
    do_move(1, 1'b0);
    check_eq("rst_row0", game_board, 16'h0002);
    check_eq("rst_p1", player_cells[1], 0);

    // Random games, mixing held requests and full-column attempts.
    for (int g = 0; g < 8; g++) begin
      int moves;
      pulse_new_game();
      det_en = ($urandom_range(0, 3) != 0);
      moves = 0;
      while (!m_over && moves < 40) begin
        do_move($urandom_range(0, 3), $urandom_range(0, 3) == 0);
        moves++;
      end
      check_eq("rand_end", game_over, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
